// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: the driving side owns the
// start/load/control inputs, the timer owns the count and status outputs.
interface countdown_timer_if #(
    parameter int COUNT_WIDTH = 32,
    parameter int EXP_WIDTH   = 16
);
    logic                   start;
    logic [COUNT_WIDTH-1:0] load_val;
    logic                   reload_en;
    logic                   pause;
    logic                   abort;
    logic                   clr_stats;
    logic [COUNT_WIDTH-1:0] count_out;
    logic                   busy;
    logic                   done;
    logic [EXP_WIDTH-1:0]   expire_cnt;

    modport master (
        output start,
        output load_val,
        output reload_en,
        output pause,
        output abort,
        output clr_stats,
        input  count_out,
        input  busy,
        input  done,
        input  expire_cnt
    );

    modport slave (
        input  start,
        input  load_val,
        input  reload_en,
        input  pause,
        input  abort,
        input  clr_stats,
        output count_out,
        output busy,
        output done,
        output expire_cnt
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with pause, abort, optional auto-reload and a
// saturating count of expiry events. All outputs come straight from flops.
module countdown_timer #(
    parameter int COUNT_WIDTH = 32,
    parameter int EXP_WIDTH   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    countdown_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
    localparam logic [EXP_WIDTH-1:0]   EXP_MAX   = '1;

    state_t                 state;
    state_t                 state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [COUNT_WIDTH-1:0] reload_reg;
    logic [COUNT_WIDTH-1:0] reload_next;
    logic                   expire;
    logic                   done_q;
    logic                   busy_q;
    logic [EXP_WIDTH-1:0]   expire_cnt;
    logic [EXP_WIDTH-1:0]   expire_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority is abort, then start (IDLE only), then pause, then decrement.
    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload_reg;
        expire      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.abort && bus.start) begin
                    reload_next = bus.load_val;
                    if (bus.load_val == '0) begin
                        expire = 1'b1;
                    end else begin
                        count_next = bus.load_val;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    count_next = '0;
                    state_next = IDLE;
                end else if (bus.pause) begin
                    state_next = HOLD;
                end else if (count > COUNT_ONE) begin
                    count_next = count - COUNT_ONE;
                end else begin
                    expire = 1'b1;
                    if (bus.reload_en) begin
                        count_next = reload_reg;
                    end else begin
                        count_next = '0;
                        state_next = IDLE;
                    end
                end
            end
            HOLD: begin
                if (bus.abort) begin
                    count_next = '0;
                    state_next = IDLE;
                end else if (!bus.pause) begin
                    state_next = RUN;
                end
            end
            default: begin
                count_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Clearing the statistics beats a coincident expiry.
    always_comb begin
        expire_next = expire_cnt;
        if (bus.clr_stats) begin
            expire_next = '0;
        end else if (expire && (expire_cnt != EXP_MAX)) begin
            expire_next = expire_cnt + EXP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            reload_reg <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            expire_cnt <= '0;
        end else begin
            count      <= count_next;
            reload_reg <= reload_next;
            done_q     <= expire;
            busy_q     <= (state_next != IDLE);
            expire_cnt <= expire_next;
        end
    end

    assign bus.count_out  = count;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.expire_cnt = expire_cnt;

    // The registered busy flag must always agree with the state register.
    assert property (@(posedge clk) disable iff (!rst_n) busy_q == (state != IDLE));
    assert property (@(posedge clk) disable iff (!rst_n) (state == IDLE) |-> (count == '0));

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one default-width instance for the main
// behaviour and a narrow EXP_WIDTH=2 instance for expiry-counter saturation.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    countdown_timer_if #(.COUNT_WIDTH(32), .EXP_WIDTH(16)) bus ();
    countdown_timer_if #(.COUNT_WIDTH(8),  .EXP_WIDTH(2))  bus_s ();

    countdown_timer #(.COUNT_WIDTH(32), .EXP_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    countdown_timer #(.COUNT_WIDTH(8), .EXP_WIDTH(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int pause_exp [10] = '{5, 4, 3, 3, 3, 3, 3, 2, 1, 0};

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic check_state(input string tag, input int exp_count,
                               input logic exp_busy, input logic exp_done);
        checkOutput({tag, ".count"}, bus.count_out, exp_count);
        checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
        checkOutput({tag, ".done"}, 32'(bus.done), 32'(exp_done));
    endtask

    task automatic check_expire(input string tag, input int exp_val);
        checkOutput({tag, ".expire"}, 32'(bus.expire_cnt), exp_val);
    endtask

    task automatic applyStimulus(input logic s, input logic [31:0] lv, input logic rl,
                                 input logic p, input logic ab, input logic clr);
        bus.start     = s;
        bus.load_val  = lv;
        bus.reload_en = rl;
        bus.pause     = p;
        bus.abort     = ab;
        bus.clr_stats = clr;
    endtask

    // Outputs are read 1ns after the rising edge; inputs change at the same point.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_s.start     = 1'b0;
        bus_s.load_val  = 8'd0;
        bus_s.reload_en = 1'b0;
        bus_s.pause     = 1'b0;
        bus_s.abort     = 1'b0;
        bus_s.clr_stats = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 1'b0, 1'b0);
        check_expire("reset", 0);
        #3;
        rst_n = 1'b1;
        next_cycle();

        // Single run of 5.
        applyStimulus(1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 5; i >= 1; i--) begin
            check_state($sformatf("single.n%0d", i), i, 1'b1, 1'b0);
            next_cycle();
        end
        check_state("single.expiry", 0, 1'b0, 1'b1);
        check_expire("single.expiry", 1);
        next_cycle();
        check_state("single.after", 0, 1'b0, 1'b0);

        // Periodic run of 4, three reloads, then a final non-reloading period.
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        check_expire("reload.clr", 0);
        applyStimulus(1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_state("reload.c0", 4, 1'b1, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            check_state($sformatf("reload.c%0d", c), ((c % 4) == 0) ? 4 : 4 - (c % 4),
                        1'b1, (c % 4) == 0);
        end
        check_expire("reload.c12", 3);
        bus.reload_en = 1'b0;
        for (int c = 13; c <= 16; c++) begin
            next_cycle();
            check_state($sformatf("reload.c%0d", c), 16 - c, c < 16, c == 16);
        end
        check_expire("reload.end", 4);

        // Run of 6 with pause held for three cycles once the count reaches 3.
        applyStimulus(1'b1, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("pause.c0", 6, 1'b1, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            check_state($sformatf("pause.c%0d", c), pause_exp[c-1], c < 10, c == 10);
            bus.pause = (c >= 3) && (c <= 5);
        end
        check_expire("pause.end", 5);

        // Start ignored mid-run, then abort at count 2 with no done.
        applyStimulus(1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        check_state("abort.c0", 5, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        check_state("abort.c1", 4, 1'b1, 1'b0);
        next_cycle();
        check_state("abort.c2", 3, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        check_state("abort.c3", 2, 1'b1, 1'b0);
        bus.abort = 1'b1;
        for (int c = 4; c <= 6; c++) begin
            next_cycle();
            bus.abort = 1'b0;
            check_state($sformatf("abort.c%0d", c), 0, 1'b0, 1'b0);
        end
        check_expire("abort.end", 5);

        // Zero-length run.
        applyStimulus(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("zero.pulse", 0, 1'b0, 1'b1);
        check_expire("zero.pulse", 6);
        next_cycle();
        check_state("zero.after", 0, 1'b0, 1'b0);

        // Asynchronous reset mid-run at count 7.
        applyStimulus(1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        next_cycle();
        check_state("rstmid.before", 7, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_state("rstmid.async", 0, 1'b0, 1'b0);
        check_expire("rstmid.async", 0);
        #3;
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            check_state($sformatf("rstmid.c%0d", c), 0, 1'b0, 1'b0);
        end

        // Narrow expiry counter: periodic run of 2, saturation, then clear on expiry.
        bus_s.load_val  = 8'd2;
        bus_s.reload_en = 1'b1;
        bus_s.start     = 1'b1;
        next_cycle();
        bus_s.start = 1'b0;
        checkOutput("sat.c0.count", 32'(bus_s.count_out), 2);
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            checkOutput($sformatf("sat.c%0d.done", c), 32'(bus_s.done), 32'((c % 2) == 0));
            checkOutput($sformatf("sat.c%0d.expire", c), 32'(bus_s.expire_cnt),
                        ((c / 2) > 3) ? 3 : (c / 2));
        end
        next_cycle();
        bus_s.clr_stats = 1'b1;
        next_cycle();
        bus_s.clr_stats = 1'b0;
        checkOutput("sat.clr.done", 32'(bus_s.done), 1);
        checkOutput("sat.clr.expire", 32'(bus_s.expire_cnt), 0);
        next_cycle();
        next_cycle();
        checkOutput("sat.resume.done", 32'(bus_s.done), 1);
        checkOutput("sat.resume.expire", 32'(bus_s.expire_cnt), 1);
        bus_s.abort = 1'b1;
        next_cycle();
        bus_s.abort = 1'b0;
        checkOutput("sat.abort.busy", 32'(bus_s.busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer for ASE latency and timeout modelling; the decrementing counterpart of the generic up-counter. A start handshake loads a count. The timer decrements once per unpaused cycle and emits a one-cycle `done` pulse when the count reaches zero. It can optionally auto-reload for periodic events. Used by the ASE latency scoreboard and watchdog logic wherever a request must be released a fixed number of cycles after it is issued.

## Interface
Parameters:
- `COUNT_WIDTH`, default 32: width of the load value and the running count.
- `EXP_WIDTH`, default 16: width of the saturating expiry-event counter.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to load `load_val` and begin counting; sampled only in IDLE.
- `load_val`  in  COUNT_WIDTH  initial count; also latched as the reload value.
- `reload_en`  in  1  when 1 at expiry, reload the latched value and keep running.
- `pause`  in  1  freeze the count while high.
- `abort`  in  1  cancel the current run; no `done` is generated.
- `clr_stats`  in  1  synchronous clear of `expire_cnt`.
- `count_out`  out  COUNT_WIDTH  current remaining count.
- `busy`  out  1  high in RUN or HOLD.
- `done`  out  1  one-cycle expiry pulse.
- `expire_cnt`  out  EXP_WIDTH  number of expiries; saturates at all-ones.

## Operation
- FSM states: IDLE, RUN, HOLD. Reset state is IDLE.
- Input priority, highest first: `abort`, `start` (IDLE only), `pause`, decrement.
- IDLE:
  - `start`=1 and `load_val`≠0: count ← `load_val`, reload_reg ← `load_val`, go to RUN.
  - `start`=1 and `load_val`=0: zero-length run. `done` pulses on the next cycle, state stays IDLE, `expire_cnt` increments.
- RUN:
  - `abort`: count ← 0, go to IDLE, `done` stays 0.
  - else `pause`: go to HOLD; count holds.
  - else count>1: count ← count−1.
  - else count==1 (expiry): `done` ← 1 and `expire_cnt` increments.
    - `reload_en`=1: count ← reload_reg, stay in RUN.
    - `reload_en`=0: count ← 0, go to IDLE.
- HOLD:
  - `abort`: go to IDLE, count ← 0.
  - `pause`=0: go to RUN. No decrement on the exit cycle; decrementing resumes the following cycle.
  - otherwise the count is frozen.
- `start` in RUN or HOLD is ignored; it never restarts a run in flight.
- `expire_cnt` saturates at 2^EXP_WIDTH−1. If `clr_stats` and an expiry occur in the same cycle, `clr_stats` wins and the result is 0.
- Arithmetic is unsigned and the count never wraps below 0.
- `busy` is a registered decode of the state: 1 in RUN or HOLD.

## Timing
- Reset values: `count_out`=0, `busy`=0, `done`=0, `expire_cnt`=0, state=IDLE.
- Assertion of `rst_n`=0 takes effect immediately, including mid-run. No `done` is produced for a run killed by reset.
- All outputs are registered.
- Start latency: with `start` sampled at edge E0, `count_out`=N and `busy`=1 after E0.
- Expiry latency (N≥1, no pause): `done`=1 for exactly one cycle after edge E0+N. In that same cycle `count_out`=0 and `busy`=0, or `count_out`=N and `busy`=1 when reloading.
- Each paused cycle, including the HOLD-exit cycle, adds exactly one cycle to the expiry latency. Pause asserted at RUN entry counts from the next edge.
- Periodic mode: `done` pulses every N cycles. There is no gap cycle at reload.
- Re-arm: `start` can be accepted in the cycle after an expiry, because the FSM is back in IDLE. This gives a back-to-back period of N+1.
- `load_val` is sampled only on the cycle `start` is accepted. Later changes have no effect until the next `start`.

## Test plan
- Reset, then `start` with `load_val`=5: `busy` and `count_out` read 5,4,3,2,1 on successive cycles. `done` is high for 1 cycle 5 cycles after the start edge, with `count_out`=0, `busy`=0, `expire_cnt`=1.
- `load_val`=4 with `reload_en`=1 for 3 periods: `done` pulses at cycles 4, 8 and 12, `busy` stays high throughout, `expire_cnt`=3. Then drop `reload_en`: the run ends at cycle 16.
- `load_val`=6 with `pause` high for 3 cycles starting at count=3: the count holds at 3, and `done` arrives 4 cycles later than with no pause (3 paused cycles plus the HOLD-exit cycle).
- `abort` at count=2, plus `start` during RUN: `start` has no effect; after `abort`, `count_out`=0, `busy`=0, and no `done`. Also `start` with `load_val`=0: `done` pulses the next cycle and `busy` stays 0.
- Assert `rst_n` low asynchronously mid-run at count=7: all outputs are 0 immediately. Set `EXP_WIDTH`=2 and produce 5 expiries: `expire_cnt` sticks at 3. `clr_stats` coincident with an expiry gives 0.
